// File: rtl/zmips_pkg.sv
// Shared zMIPS decode definitions: ALU op encodings, opcode/funct constants and the decoded-entry bundle.
package zmips_pkg;

  typedef enum logic [3:0] {
    A_ADD = 4'h0,
    A_SUB = 4'h1,
    A_AND = 4'h2,
    A_OR  = 4'h4,
    A_EOR = 4'h6,
    A_NOP = 4'h8,
    A_SLL = 4'hA,
    A_SRA = 4'hC,
    A_SRL = 4'hE
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [4:0]  alu_shamt;
    logic        alu_cin;
    logic        a_sel_imm;
    logic        b_sel_imm;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        set_lt;
    logic        illegal;
  } dec_t;

  localparam int unsigned DEC_W = $bits(dec_t);

endpackage

// File: rtl/zmips_alu_decode_if.sv
// Fetch-side instruction stream and execute-side decoded stream of the zMIPS ALU decoder.
interface zmips_alu_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic        alu_cin;
  logic        a_sel_imm;
  logic        b_sel_imm;
  logic [31:0] imm;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        set_lt;
  logic        illegal;

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_op, alu_shamt, alu_cin, a_sel_imm, b_sel_imm,
           imm, rs, rt, rd, set_lt, illegal
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_op, alu_shamt, alu_cin, a_sel_imm, b_sel_imm,
           imm, rs, rt, rd, set_lt, illegal
  );
endinterface

// File: rtl/zmips_dec_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready comes straight from the skid-valid flop.
module zmips_dec_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      // A full skid blocks in_ready, so refilling main from skid never races a new accept.
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_valid;
        if (in_valid) main_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/zmips_alu_decode.sv
// zMIPS decode stage: instruction -> ALU controls, buffered through a 2-entry skid, with illegal counter.
// Optional SLT/SLTU/SLTI/SLTIU decode is enabled by defining ZMIPS_DEC_SLT_EN.
module zmips_alu_decode
  import zmips_pkg::*;
#(
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  zmips_alu_decode_if.slave    bus,
  output logic [ILL_CNT_W-1:0] ill_cnt
);
  dec_t             dec;
  dec_t             head;
  logic [DEC_W-1:0] head_bits;
  logic [5:0]       opc;
  logic [5:0]       fn;
  logic [31:0]      sext;
  logic [31:0]      zext;
  logic             ill;

  assign opc  = bus.instr[31:26];
  assign fn   = bus.instr[5:0];
  assign sext = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign zext = {16'h0, bus.instr[15:0]};

  always_comb begin
    dec.alu_op    = A_ADD;
    dec.alu_shamt = '0;
    dec.alu_cin   = 1'b0;
    dec.a_sel_imm = 1'b0;
    dec.b_sel_imm = 1'b0;
    dec.imm       = '0;
    dec.rs        = bus.instr[25:21];
    dec.rt        = bus.instr[20:16];
    dec.rd        = bus.instr[20:16];
    dec.set_lt    = 1'b0;
    dec.illegal   = 1'b0;
    ill           = 1'b0;
    if (opc == OP_RTYPE) begin
      dec.rd = bus.instr[15:11];
      case (fn)
        FN_ADD, FN_ADDU: dec.alu_op = A_ADD;
        FN_SUB, FN_SUBU: begin dec.alu_op = A_SUB; dec.alu_cin = 1'b1; end
        FN_AND:          dec.alu_op = A_AND;
        FN_OR:           dec.alu_op = A_OR;
        FN_XOR:          dec.alu_op = A_EOR;
        FN_SLL:          begin dec.alu_op = A_SLL; dec.alu_shamt = bus.instr[10:6]; end
        FN_SRL:          begin dec.alu_op = A_SRL; dec.alu_shamt = bus.instr[10:6]; end
        FN_SRA:          begin dec.alu_op = A_SRA; dec.alu_shamt = bus.instr[10:6]; end
`ifdef ZMIPS_DEC_SLT_EN
        FN_SLT, FN_SLTU: begin dec.alu_op = A_SUB; dec.alu_cin = 1'b1; dec.set_lt = 1'b1; end
`endif
        default:         ill = 1'b1;
      endcase
    end else begin
      case (opc)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin dec.b_sel_imm = 1'b1; dec.imm = sext; end
        OP_ANDI: begin dec.alu_op = A_AND; dec.b_sel_imm = 1'b1; dec.imm = zext; end
        OP_ORI:  begin dec.alu_op = A_OR;  dec.b_sel_imm = 1'b1; dec.imm = zext; end
        OP_XORI: begin dec.alu_op = A_EOR; dec.b_sel_imm = 1'b1; dec.imm = zext; end
        OP_LUI:  begin dec.alu_op = A_NOP; dec.a_sel_imm = 1'b1; dec.imm = {bus.instr[15:0], 16'h0}; end
`ifdef ZMIPS_DEC_SLT_EN
        OP_SLTI, OP_SLTIU: begin
          dec.alu_op = A_SUB; dec.alu_cin = 1'b1; dec.b_sel_imm = 1'b1;
          dec.imm = sext; dec.set_lt = 1'b1;
        end
`endif
        default: ill = 1'b1;
      endcase
    end
    // Illegal entries carry a clean ADD with no selects, immediates or register indices.
    if (ill) begin
      dec.alu_op    = A_ADD;
      dec.alu_shamt = '0;
      dec.alu_cin   = 1'b0;
      dec.a_sel_imm = 1'b0;
      dec.b_sel_imm = 1'b0;
      dec.imm       = '0;
      dec.rs        = '0;
      dec.rt        = '0;
      dec.rd        = '0;
      dec.set_lt    = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

  zmips_dec_skid #(.W(DEC_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (dec),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head_bits)
  );

  assign head          = dec_t'(head_bits);
  assign bus.alu_op    = head.alu_op;
  assign bus.alu_shamt = head.alu_shamt;
  assign bus.alu_cin   = head.alu_cin;
  assign bus.a_sel_imm = head.a_sel_imm;
  assign bus.b_sel_imm = head.b_sel_imm;
  assign bus.imm       = head.imm;
  assign bus.rs        = head.rs;
  assign bus.rt        = head.rt;
  assign bus.rd        = head.rd;
  assign bus.set_lt    = head.set_lt;
  assign bus.illegal   = head.illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (!flush && bus.in_valid && bus.in_ready && dec.illegal && (ill_cnt != '1)) begin
      ill_cnt <= ill_cnt + ILL_CNT_W'(1);
    end
  end
endmodule
